// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and widths for the memory pipeline stage
package mem_stage_pkg;

  localparam int DATA_BITS = 24;
  localparam int DEST_BITS = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Memory op latched on entry to ACCESS; the address is a slice of alu_result
  typedef struct packed {
    logic                 we;
    logic                 wbe;
    logic [DEST_BITS-1:0] dest;
    logic [DATA_BITS-1:0] wdata;
    logic [DATA_BITS-1:0] alu_result;
  } mem_op_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - 8-bit cycle counter flagging the last allowed ACCESS cycle
module mem_timeout_counter (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic [7:0] limit_i,
  output logic       expire_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Clear has priority so each new access starts counting from zero
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 8'd0;
    end else if (enable_i) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // High during the cycle in which the stage must give up if no ack arrives
  assign expire_o = enable_i && (count_q == (limit_i - 8'd1));

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with stalling memory access and timeout abort
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 writeback_enable,
  input  logic                 mem_read_enable,
  input  logic                 mem_write_enable,
  input  logic [DEST_BITS-1:0] instruction_dest,
  input  logic [DATA_BITS-1:0] alu_result,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 wb_valid,
  output logic                 writeback_enable_out,
  output logic [DEST_BITS-1:0] instruction_dest_out,
  output logic [DATA_BITS-1:0] wb_data,
  output logic                 mem_error
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);

  state_e               state_q, state_d;
  mem_op_t              op_q, op_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 wbe_q, wbe_d;
  logic [DEST_BITS-1:0] dest_q, dest_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 err_q, err_d;
  logic                 stall_raw;
  logic                 expire;
  logic                 in_access;

  assign in_access = (state_q == ACCESS);

  mem_timeout_counter u_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (!in_access),
    .enable_i (in_access),
    .limit_i  (TIMEOUT_LIMIT),
    .expire_o (expire)
  );

  // Next state, op capture, writeback fields and stall request
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    wb_valid_d = 1'b0;
    wbe_d      = 1'b0;
    dest_d     = dest_q;
    data_d     = data_q;
    err_d      = err_q;
    stall_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (mem_read_enable || mem_write_enable) begin
            // A read+write combination is treated as a write
            stall_raw        = 1'b1;
            op_d.we          = mem_write_enable;
            op_d.wbe         = writeback_enable;
            op_d.dest        = instruction_dest;
            op_d.wdata       = write_data;
            op_d.alu_result  = alu_result;
            state_d          = ACCESS;
          end else begin
            wb_valid_d = 1'b1;
            wbe_d      = writeback_enable;
            dest_d     = instruction_dest;
            data_d     = alu_result;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wbe_d      = op_q.wbe;
          dest_d     = op_q.dest;
          data_d     = op_q.we ? op_q.alu_result : mem_rdata;
        end else if (expire) begin
          // Abort: retire the instruction without a register write
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          err_d      = 1'b1;
        end else begin
          stall_raw = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured op and registered writeback outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      wb_valid_q <= 1'b0;
      wbe_q      <= 1'b0;
      dest_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      wb_valid_q <= wb_valid_d;
      wbe_q      <= wbe_d;
      dest_q     <= dest_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign stall                = rst && stall_raw;
  assign mem_req              = rst && in_access;
  assign mem_we               = op_q.we;
  assign mem_addr             = op_q.alu_result[ADDR_BITS-1:0];
  assign mem_wdata            = op_q.wdata;
  assign wb_valid             = wb_valid_q;
  assign writeback_enable_out = wbe_q;
  assign instruction_dest_out = dest_q;
  assign wb_data              = data_q;
  assign mem_error            = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        writeback_enable = 1'b0;
  logic        mem_read_enable = 1'b0;
  logic        mem_write_enable = 1'b0;
  logic [3:0]  instruction_dest = 4'd0;
  logic [23:0] alu_result = 24'd0;
  logic [23:0] write_data = 24'd0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [23:0] mem_rdata = 24'd0;
  logic        wb_valid;
  logic        writeback_enable_out;
  logic [3:0]  instruction_dest_out;
  logic [23:0] wb_data;
  logic        mem_error;

  mem_stage #(.ADDR_BITS(16), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .writeback_enable(writeback_enable), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .instruction_dest(instruction_dest),
    .alu_result(alu_result), .write_data(write_data), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .writeback_enable_out(writeback_enable_out),
    .instruction_dest_out(instruction_dest_out), .wb_data(wb_data),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Observations from do_op
  int          o_stall, o_req, o_mid_wbv, o_idle_req;
  logic        o_const, o_we, o_wbv, o_wbe, o_err;
  logic [15:0] o_addr;
  logic [23:0] o_wdata, o_data;
  logic [3:0]  o_dest;
  // Observations from do_idle
  logic        i_req, i_stall, i_wbv, i_wbe, i_err;
  logic [23:0] i_data;
  logic [3:0]  i_dest;

  // Presents one instruction and plays the memory side; ack_after >= T means never ack
  task automatic do_op(input logic rd, input logic wr, input logic wbe, input logic [3:0] dest,
                       input logic [23:0] alu, input logic [23:0] wd, input int ack_after,
                       input logic [23:0] rdata);
    int last;
    in_valid = 1'b1; mem_read_enable = rd; mem_write_enable = wr;
    writeback_enable = wbe; instruction_dest = dest; alu_result = alu; write_data = wd;
    mem_ack = 1'b0;
    o_stall = 0; o_req = 0; o_mid_wbv = 0; o_const = 1'b1;
    @(negedge clk);
    o_stall += int'(stall); o_idle_req = int'(mem_req);
    @(posedge clk); #1;
    if (rd | wr) begin
      last = (ack_after < T) ? ack_after : T - 1;
      for (int k = 0; k <= last; k++) begin
        o_mid_wbv += int'(wb_valid);
        mem_ack = (k == ack_after);
        mem_rdata = (k == ack_after) ? rdata : 24'($urandom);
        @(negedge clk);
        o_stall += int'(stall); o_req += int'(mem_req);
        if (k == 0) begin
          o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
        end else if (mem_we !== o_we || mem_addr !== o_addr || mem_wdata !== o_wdata) begin
          o_const = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; mem_ack = 1'b0;
    o_wbv = wb_valid; o_wbe = writeback_enable_out; o_dest = instruction_dest_out;
    o_data = wb_data; o_err = mem_error;
  endtask

  // One cycle with no instruction, optionally with a stray ack
  task automatic do_idle(input logic stray);
    in_valid = 1'b0; mem_ack = stray; mem_rdata = 24'($urandom);
    @(negedge clk);
    i_req = mem_req; i_stall = stall;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    i_wbv = wb_valid; i_wbe = writeback_enable_out; i_data = wb_data;
    i_dest = instruction_dest_out; i_err = mem_error;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; mem_read_enable = 1'b1; mem_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b exp 0", stall); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", mem_req); end
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wbv got %b exp 0", wb_valid); end
    n_vec++; if (writeback_enable_out !== 1'b0) begin n_err++; $display("FAIL rst_wbe got %b exp 0", writeback_enable_out); end
    n_vec++; if (instruction_dest_out !== 4'd0) begin n_err++; $display("FAIL rst_dest got %h exp 0", instruction_dest_out); end
    n_vec++; if (wb_data !== 24'd0) begin n_err++; $display("FAIL rst_data got %h exp 0", wb_data); end
    n_vec++; if (mem_error !== 1'b0) begin n_err++; $display("FAIL rst_err got %b exp 0", mem_error); end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; mem_read_enable = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_alu_op();
    do_op(1'b0, 1'b0, 1'b1, 4'd3, 24'h00ABCD, 24'($urandom), 0, 24'd0);
    n_vec++; if (o_stall !== 0) begin n_err++; $display("FAIL alu_stall got %0d exp 0", o_stall); end
    n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL alu_wbv got %b exp 1", o_wbv); end
    n_vec++; if (o_data !== 24'h00ABCD) begin n_err++; $display("FAIL alu_data got %h exp 00abcd", o_data); end
    n_vec++; if (o_dest !== 4'd3) begin n_err++; $display("FAIL alu_dest got %h exp 3", o_dest); end
    n_vec++; if (o_wbe !== 1'b1) begin n_err++; $display("FAIL alu_wbe got %b exp 1", o_wbe); end
  endtask

  task automatic test_load();
    do_op(1'b1, 1'b0, 1'b1, 4'd5, 24'h001234, 24'd0, 2, 24'h5A5A5A);
    n_vec++; if (o_addr !== 16'h1234) begin n_err++; $display("FAIL ld_addr got %h exp 1234", o_addr); end
    n_vec++; if (o_we !== 1'b0) begin n_err++; $display("FAIL ld_we got %b exp 0", o_we); end
    n_vec++; if (o_stall !== 3) begin n_err++; $display("FAIL ld_stall got %0d exp 3", o_stall); end
    n_vec++; if (o_req !== 3) begin n_err++; $display("FAIL ld_req got %0d exp 3", o_req); end
    n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL ld_wbv got %b exp 1", o_wbv); end
    n_vec++; if (o_data !== 24'h5A5A5A) begin n_err++; $display("FAIL ld_data got %h exp 5a5a5a", o_data); end
    n_vec++; if (o_dest !== 4'd5) begin n_err++; $display("FAIL ld_dest got %h exp 5", o_dest); end
  endtask

  task automatic test_store();
    do_op(1'b0, 1'b1, 1'b0, 4'd7, 24'h000010, 24'hFFFFFF, 0, 24'h123456);
    n_vec++; if (o_we !== 1'b1) begin n_err++; $display("FAIL st_we got %b exp 1", o_we); end
    n_vec++; if (o_wdata !== 24'hFFFFFF) begin n_err++; $display("FAIL st_wdata got %h exp ffffff", o_wdata); end
    n_vec++; if (o_addr !== 16'h0010) begin n_err++; $display("FAIL st_addr got %h exp 0010", o_addr); end
    n_vec++; if (o_stall !== 1) begin n_err++; $display("FAIL st_stall got %0d exp 1", o_stall); end
    n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL st_wbv got %b exp 1", o_wbv); end
    n_vec++; if (o_data !== 24'h000010) begin n_err++; $display("FAIL st_data got %h exp 000010", o_data); end
    n_vec++; if (o_wbe !== 1'b0) begin n_err++; $display("FAIL st_wbe got %b exp 0", o_wbe); end
  endtask

  // Reference model: each instruction retires once; memory ops take 1 + ack delay stall cycles
  task automatic test_random();
    logic        rd, wr, wbe, ismem;
    logic [3:0]  dest;
    logic [23:0] alu, wd, rdata, exp_data;
    logic [3:0]  exp_dest;
    int          ack, kind;
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      rd = (kind == 1) || (kind == 3);
      wr = (kind >= 2);
      ismem = rd | wr;
      wbe = 1'($urandom); dest = 4'($urandom);
      alu = 24'($urandom); wd = 24'($urandom); rdata = 24'($urandom);
      ack = int'($urandom_range(0, T - 1));
      do_op(rd, wr, wbe, dest, alu, wd, ack, rdata);
      exp_data = (!ismem || wr) ? alu : rdata;
      exp_dest = dest;
      n_vec++; if (o_stall !== (ismem ? 1 + ack : 0)) begin n_err++; $display("FAIL rnd_stall[%0d] got %0d exp %0d", i, o_stall, ismem ? 1 + ack : 0); end
      n_vec++; if (o_req !== (ismem ? 1 + ack : 0)) begin n_err++; $display("FAIL rnd_req[%0d] got %0d exp %0d", i, o_req, ismem ? 1 + ack : 0); end
      n_vec++; if (o_idle_req !== 0) begin n_err++; $display("FAIL rnd_idle_req[%0d] got %0d exp 0", i, o_idle_req); end
      n_vec++; if (o_mid_wbv !== 0) begin n_err++; $display("FAIL rnd_mid_wbv[%0d] got %0d exp 0", i, o_mid_wbv); end
      if (ismem) begin
        n_vec++; if (o_addr !== alu[15:0]) begin n_err++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, o_addr, alu[15:0]); end
        n_vec++; if (o_we !== wr) begin n_err++; $display("FAIL rnd_we[%0d] got %b exp %b", i, o_we, wr); end
        n_vec++; if (o_const !== 1'b1) begin n_err++; $display("FAIL rnd_const[%0d] got %b exp 1", i, o_const); end
        if (wr) begin
          n_vec++; if (o_wdata !== wd) begin n_err++; $display("FAIL rnd_wdata[%0d] got %h exp %h", i, o_wdata, wd); end
        end
      end
      n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL rnd_wbv[%0d] got %b exp 1", i, o_wbv); end
      n_vec++; if (o_wbe !== wbe) begin n_err++; $display("FAIL rnd_wbe[%0d] got %b exp %b", i, o_wbe, wbe); end
      n_vec++; if (o_dest !== exp_dest) begin n_err++; $display("FAIL rnd_dest[%0d] got %h exp %h", i, o_dest, exp_dest); end
      n_vec++; if (o_data !== exp_data) begin n_err++; $display("FAIL rnd_data[%0d] got %h exp %h", i, o_data, exp_data); end
      n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL rnd_err[%0d] got %b exp 0", i, o_err); end
      if ($urandom_range(0, 1) == 1) begin
        do_idle(1'($urandom));
        n_vec++; if (i_req !== 1'b0) begin n_err++; $display("FAIL idle_req[%0d] got %b exp 0", i, i_req); end
        n_vec++; if (i_stall !== 1'b0) begin n_err++; $display("FAIL idle_stall[%0d] got %b exp 0", i, i_stall); end
        n_vec++; if (i_wbv !== 1'b0) begin n_err++; $display("FAIL idle_wbv[%0d] got %b exp 0", i, i_wbv); end
        n_vec++; if (i_wbe !== 1'b0) begin n_err++; $display("FAIL idle_wbe[%0d] got %b exp 0", i, i_wbe); end
        n_vec++; if (i_data !== exp_data) begin n_err++; $display("FAIL idle_hold_data[%0d] got %h exp %h", i, i_data, exp_data); end
        n_vec++; if (i_dest !== exp_dest) begin n_err++; $display("FAIL idle_hold_dest[%0d] got %h exp %h", i, i_dest, exp_dest); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a1, a2, rdv;
    a1 = 24'($urandom); a2 = 24'($urandom); rdv = 24'($urandom);
    do_op(1'b1, 1'b0, 1'b1, 4'd2, a1, 24'd0, 0, rdv);
    n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL b2b_ld_wbv got %b exp 1", o_wbv); end
    n_vec++; if (o_data !== rdv) begin n_err++; $display("FAIL b2b_ld_data got %h exp %h", o_data, rdv); end
    do_op(1'b0, 1'b1, 1'b0, 4'd4, a2, 24'h0F0F0F, 0, 24'd0);
    n_vec++; if (o_stall !== 1) begin n_err++; $display("FAIL b2b_st_stall got %0d exp 1", o_stall); end
    n_vec++; if (o_mid_wbv !== 0) begin n_err++; $display("FAIL b2b_dup_wbv got %0d exp 0", o_mid_wbv); end
    n_vec++; if (o_addr !== a2[15:0]) begin n_err++; $display("FAIL b2b_st_addr got %h exp %h", o_addr, a2[15:0]); end
    n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL b2b_st_wbv got %b exp 1", o_wbv); end
    n_vec++; if (o_data !== a2) begin n_err++; $display("FAIL b2b_st_data got %h exp %h", o_data, a2); end
    for (int j = 0; j < 2; j++) begin
      do_idle(1'b1);
      n_vec++; if (i_req !== 1'b0) begin n_err++; $display("FAIL stray_req[%0d] got %b exp 0", j, i_req); end
      n_vec++; if (i_wbv !== 1'b0) begin n_err++; $display("FAIL stray_wbv[%0d] got %b exp 0", j, i_wbv); end
      n_vec++; if (i_data !== a2) begin n_err++; $display("FAIL stray_data[%0d] got %h exp %h", j, i_data, a2); end
    end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1'b1; mem_read_enable = 1'b1; mem_write_enable = 1'b0;
    alu_result = 24'h00BEEF; mem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rml_req_a0 got %b exp 1", mem_req); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rml_req got %b exp 0", mem_req); end
    n_vec++; if (stall !== 1'b0) begin n_err++; $display("FAIL rml_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; mem_read_enable = 1'b0;
    n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL rml_wbv got %b exp 0", wb_valid); end
    do_idle(1'b0);
    n_vec++; if (i_wbv !== 1'b0) begin n_err++; $display("FAIL rml_idle_wbv got %b exp 0", i_wbv); end
    n_vec++; if (i_req !== 1'b0) begin n_err++; $display("FAIL rml_idle_req got %b exp 0", i_req); end
    do_op(1'b0, 1'b0, 1'b1, 4'd6, 24'h0A0B0C, 24'd0, 0, 24'd0);
    n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL rml_alu_wbv got %b exp 1", o_wbv); end
    n_vec++; if (o_data !== 24'h0A0B0C) begin n_err++; $display("FAIL rml_alu_data got %h exp 0a0b0c", o_data); end
  endtask

  task automatic test_timeout();
    do_op(1'b1, 1'b0, 1'b1, 4'd9, 24'h00CAFE, 24'd0, 1000, 24'd0);
    n_vec++; if (o_req !== T) begin n_err++; $display("FAIL to_req got %0d exp %0d", o_req, T); end
    n_vec++; if (o_stall !== T) begin n_err++; $display("FAIL to_stall got %0d exp %0d", o_stall, T); end
    n_vec++; if (o_wbv !== 1'b1) begin n_err++; $display("FAIL to_wbv got %b exp 1", o_wbv); end
    n_vec++; if (o_wbe !== 1'b0) begin n_err++; $display("FAIL to_wbe got %b exp 0", o_wbe); end
    n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL to_err got %b exp 1", o_err); end
    for (int j = 0; j < 3; j++) begin
      do_idle(1'b0);
      n_vec++; if (i_err !== 1'b1) begin n_err++; $display("FAIL to_sticky[%0d] got %b exp 1", j, i_err); end
      n_vec++; if (i_req !== 1'b0) begin n_err++; $display("FAIL to_idle_req[%0d] got %b exp 0", j, i_req); end
    end
    do_op(1'b0, 1'b0, 1'b1, 4'd1, 24'h111111, 24'd0, 0, 24'd0);
    n_vec++; if (o_data !== 24'h111111) begin n_err++; $display("FAIL to_after_data got %h exp 111111", o_data); end
    n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL to_after_err got %b exp 1", o_err); end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_vec++; if (mem_error !== 1'b0) begin n_err++; $display("FAIL to_clear got %b exp 0", mem_error); end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_random();
    test_back_to_back();
    test_reset_mid_load();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
